// File: rtl/dtc_share_sched.sv
// dtc_share_sched
//   Round-robin scheduler that time-shares one external combinational
//   decision-tree classifier among NREQ requesters. One request is in flight
//   at a time: accept (IDLE) -> classify (EVAL) -> hold result (HOLD).
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake, ready is one-hot or zero
//   req_data          : flattened features, requester i at [i*W +: W]
//   dtc_inp/dtc_outp  : registered classifier input / classifier result
//   res_valid/ready   : result handshake
//   res_data/level/id : captured result, its popcount, owning requester
//   busy              : high while a request is in flight (EVAL or HOLD)
//   done_cnt          : saturating count of result handshakes
//   thermo_err        : sticky non-thermometer flag
//
// Build option
//   DTC_THERMO_CHECK_EN : when defined, EVAL flags any classifier output that
//   is not of the form 0..01..1. When undefined, thermo_err is tied low.

module dtc_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 6,
  parameter int OW   = 6,
  parameter int CW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_data,
  output logic [W-1:0]              dtc_inp,
  input  logic [OW-1:0]             dtc_outp,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OW-1:0]             res_data,
  output logic [$clog2(OW+1)-1:0]   res_level,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic                      busy,
  output logic [CW-1:0]             done_cnt,
  output logic                      thermo_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int LW  = $clog2(OW+1);
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           accept;
  logic [IDW:0]   cand;
  logic [LW-1:0]  outp_level;
  logic [W-1:0]   req_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*W +: W];
  end

  // Search from ptr upward, wrapping modulo NREQ; first valid requester wins.
  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Next state and handshake outputs. Ready is masked by rst so a request
  // cannot appear to transfer on an edge where reset wins.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          accept             = 1'b1;
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = EVAL;
        end
      end
      EVAL:    state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    outp_level = '0;
    for (int i = 0; i < OW; i++) outp_level = outp_level + LW'(dtc_outp[i]);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      dtc_inp   <= '0;
      res_data  <= '0;
      res_level <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      done_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // dtc_inp only moves on an accept, so the classifier stays quiet when idle.
      if (accept) begin
        dtc_inp <= req_arr[gnt_idx];
        res_id  <= gnt_idx;
        ptr     <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == EVAL) begin
        res_data  <= dtc_outp;
        res_level <= outp_level;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
        if (done_cnt != '1) done_cnt <= done_cnt + CW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef DTC_THERMO_CHECK_EN
  // A thermometer code v satisfies v & (v+1) == 0 (all-zero and all-one too).
  logic [OW-1:0] outp_inc;
  logic          thermo_q;

  assign outp_inc = dtc_outp + OW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      thermo_q <= 1'b0;
    end else if (state == EVAL && (dtc_outp & outp_inc) != '0) begin
      thermo_q <= 1'b1;
    end
  end

  assign thermo_err = thermo_q;
`else
  assign thermo_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_share_sched.sv
// tb_dtc_share_sched
//   Directed bench for dtc_share_sched with a classifier stub. The stub maps
//   a feature vector to the thermometer code of its popcount, or returns a
//   forced value. Expected results are queued when a request is driven and
//   compared when the result handshake occurs.

module tb_dtc_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int OW   = 6;
  localparam int CW   = 16;

`ifdef DTC_THERMO_CHECK_EN
  localparam logic EXP_TERR = 1'b1;
`else
  localparam logic EXP_TERR = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [5:0] data;
    int         level;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [W-1:0]      dtc_inp;
  logic [OW-1:0]     dtc_outp;
  logic              res_valid;
  logic              res_ready;
  logic [OW-1:0]     res_data;
  logic [2:0]        res_level;
  logic [1:0]        res_id;
  logic              busy;
  logic [CW-1:0]     done_cnt;
  logic              thermo_err;

  logic       force_en;
  logic [5:0] force_val;

  int   n_total = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  int   g_id[$];
  int   g_cyc[$];
  exp_t cons_e;
  int   g_tmp;

  dtc_share_sched #(.NREQ(NREQ), .W(W), .OW(OW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .dtc_inp    (dtc_inp),
    .dtc_outp   (dtc_outp),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_level  (res_level),
    .res_id     (res_id),
    .busy       (busy),
    .done_cnt   (done_cnt),
    .thermo_err (thermo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] stub_model(input logic [5:0] x);
    int         n;
    logic [6:0] t;
    n = 0;
    for (int i = 0; i < 6; i++) if (x[i]) n++;
    t = (7'd1 << n) - 7'd1;
    return t[5:0];
  endfunction

  function automatic int ones(input logic [5:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) if (x[i]) n++;
    return n;
  endfunction

  always_comb dtc_outp = force_en ? force_val : stub_model(dtc_inp);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [5:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic push_exp(input int id, input logic [5:0] d);
    exp_t e;
    e.id    = id;
    e.data  = force_en ? force_val : stub_model(d);
    e.level = ones(e.data);
    exp_q.push_back(e);
  endtask

  // Result scoreboard: pop on every result handshake.
  always @(negedge clk) begin
    #1;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        cons_e = exp_q.pop_front();
        check("res_id", 64'(res_id), 64'(cons_e.id));
        check("res_data", 64'(res_data), 64'(cons_e.data));
        check("res_level", 64'(res_level), 64'(cons_e.level));
      end
    end
  end

  // Grant monitor: ready must be one-hot-or-zero and only on valid lines.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("ready_legal",
            64'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 64'd1);
      if (|req_ready) begin
        g_tmp = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_tmp = i;
        g_id.push_back(g_tmp);
        g_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] snap;
    int          g_base;
    int          rr_ids [5];

    rr_ids = '{0, 1, 2, 3, 0};
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    force_en  = 1'b0;
    force_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle: everything quiet for 10 cycles.
    for (int j = 0; j < 10; j++) begin
      tick();
      check("idle_outputs",
            64'({req_ready, res_valid, busy, dtc_inp, res_data, res_level,
                 res_id, done_cnt, thermo_err}), 64'd0);
    end

    // Single request from requester 2.
    set_req(2, 6'b010101);
    req_valid = 4'b0100;
    push_exp(2, 6'b010101);
    #1 check("single_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check("eval_busy", 64'(busy), 64'd1);
    check("eval_ready", 64'(req_ready), 64'd0);
    check("eval_dtc_inp", 64'(dtc_inp), 64'b010101);
    check("eval_res_valid", 64'(res_valid), 64'd0);
    tick();
    check("hold_res_valid", 64'(res_valid), 64'd1);
    check("hold_res_data", 64'(res_data), 64'b000111);
    check("hold_res_level", 64'(res_level), 64'd3);
    check("hold_res_id", 64'(res_id), 64'd2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("single_done_cnt", 64'(done_cnt), 64'd1);
    check("single_res_valid_clr", 64'(res_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // Backpressure: requester 3 (ptr is 3), then hold the result 5 cycles.
    set_req(3, 6'b110110);
    req_valid = 4'b1000;
    push_exp(3, 6'b110110);
    tick();
    set_req(0, 6'b100000);
    set_req(1, 6'b101000);
    set_req(2, 6'b111011);
    req_valid = 4'b1111;
    tick();
    snap = {res_data, res_level, res_id};
    check("bp_snap_data", 64'(res_data), 64'b001111);
    for (int j = 0; j < 5; j++) begin
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_stable", 64'({res_data, res_level, res_id}), 64'(snap));
      check("bp_no_ready", 64'(req_ready), 64'd0);
      check("bp_dtc_inp", 64'(dtc_inp), 64'b110110);
      tick();
    end
    check("bp_still_hold", 64'(res_valid), 64'd1);

    // Release, then round-robin with everyone valid: 0,1,2,3,0.
    push_exp(0, 6'b100000);
    push_exp(1, 6'b101000);
    push_exp(2, 6'b111011);
    push_exp(3, 6'b110110);
    push_exp(0, 6'b100000);
    res_ready = 1'b1;
    tick();
    g_base = g_id.size();
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_done_cnt", 64'(done_cnt), 64'd2);
    #1 check("next_grant_1cycle", 64'(req_ready), 64'b0001);
    tick();
    repeat (12) tick();
    req_valid = '0;
    repeat (3) tick();
    res_ready = 1'b0;
    check("rr_grant_count", 64'(g_id.size() - g_base), 64'd5);
    if (g_id.size() - g_base == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("rr_id", 64'(g_id[g_base+k]), 64'(rr_ids[k]));
        if (k > 0) check("rr_gap", 64'(g_cyc[g_base+k] - g_cyc[g_base+k-1]), 64'd3);
      end
    end
    check("rr_done_cnt", 64'(done_cnt), 64'd7);
    check("rr_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset during EVAL: request from requester 1 is dropped.
    set_req(1, 6'b000011);
    req_valid = 4'b0010;
    tick();
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    check("rst_dtc_inp", 64'(dtc_inp), 64'd0);
    check("rst_ready_masked", 64'(req_ready), 64'd0);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1 check("rst_ptr_zero", 64'(req_ready), 64'b0001);
    #1 req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("rst_no_result", 64'(res_valid), 64'd0);
    end

    // Thermometer check: legal code first, then an illegal one.
    force_en  = 1'b1;
    force_val = 6'b011111;
    set_req(0, 6'b000001);
    req_valid = 4'b0001;
    push_exp(0, 6'b000001);
    tick();
    req_valid = '0;
    tick();
    check("terr_clean", 64'(thermo_err), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    force_val = 6'b010011;
    set_req(1, 6'b000010);
    req_valid = 4'b0010;
    push_exp(1, 6'b000010);
    tick();
    req_valid = '0;
    tick();
    check("terr_set", 64'(thermo_err), 64'(EXP_TERR));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    force_en = 1'b0;
    repeat (3) tick();
    check("terr_sticky", 64'(thermo_err), 64'(EXP_TERR));
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_done_cnt", 64'(done_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
